mem_stage: RTL and testbench

- Pipeline stage 4 (MEM). It consumes the registered EXE/MEM outputs: ALU result, RM store value, destination and control enables.
- Owns the word-addressed data memory. Memory accesses are multi-cycle; the block holds Freeze high to stall upstream stages while an access is in progress.
- Drives the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_if.sv | 35 +++
 rtl/data_memory.sv | 25 ++
 rtl/mem_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_stage.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and default constants for the MEM pipeline stage.
package mem_pkg;

  // Default geometry and timing of the data memory.
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_MEM_LATENCY = 2;

  // Width of the access-latency down counter.
  localparam int CNT_W = 4;

  // Access sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Counter load value for a given latency: the BUSY phase counts down to zero,
  // so Freeze stays high for exactly 'lat' cycles including the IDLE request cycle.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_if.sv
// EXE/MEM inputs and MEM/WB outputs of the MEM stage bundled as one port.
interface mem_if #(
  parameter int DATA_WIDTH = 32
);

  // EXE/MEM side.
  logic                  MEM_R_EN;
  logic                  MEM_W_EN;
  logic                  MEM_WB_EN;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic [DATA_WIDTH-1:0] RMVal;
  logic [3:0]            Dest;

  // Stall and MEM/WB side.
  logic                  Freeze;
  logic                  WB_EN_Out;
  logic                  MEM_R_EN_Out;
  logic [DATA_WIDTH-1:0] ALUResultOut;
  logic [DATA_WIDTH-1:0] MemDataOut;
  logic [3:0]            DestOut;
  logic                  AddrError;

  // Upstream pipeline / environment view.
  modport master (
    output MEM_R_EN, MEM_W_EN, MEM_WB_EN, ALUResult, RMVal, Dest,
    input  Freeze, WB_EN_Out, MEM_R_EN_Out, ALUResultOut, MemDataOut, DestOut, AddrError
  );

  // MEM stage view.
  modport slave (
    input  MEM_R_EN, MEM_W_EN, MEM_WB_EN, ALUResult, RMVal, Dest,
    output Freeze, WB_EN_Out, MEM_R_EN_Out, ALUResultOut, MemDataOut, DestOut, AddrError
  );

endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read, no reset.
module data_memory #(
  parameter  int DEPTH      = 64,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store port: contents change only when the stage asserts we.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle data memory access with upstream Freeze
// and the MEM/WB pipeline register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input logic  clk,
  input logic  rst_n,
  mem_if.slave bus
);

  localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] BASE_W   = DATA_WIDTH'(BASE_ADDR);
  localparam logic [DATA_WIDTH-3:0] DEPTH_W  = (DATA_WIDTH-2)'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_INIT = lat_to_cnt(MEM_LATENCY);

  // Sequencer state.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // MEM/WB register.
  logic                  wb_en_q, wb_en_d;
  logic                  r_en_q, r_en_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
  logic [3:0]            dest_q, dest_d;
  logic                  aerr_q, aerr_d;

  // Decode and control.
  logic [DATA_WIDTH-3:0] word_off_s;
  logic                  in_range_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  req_s;
  logic                  done_s;
  logic                  freeze_s;
  logic                  we_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic [DATA_WIDTH-1:0] load_data_s;

  // Byte address to word index; the low two offset bits are dropped, and an
  // address below the base wraps to a huge offset that the >= test rejects.
  always_comb begin
    word_off_s = (DATA_WIDTH-2)'((bus.ALUResult - BASE_W) >> 2'd2);
    in_range_s = (bus.ALUResult >= BASE_W) && (word_off_s < DEPTH_W);
    if (in_range_s) begin
      idx_s = word_off_s[IDX_W-1:0];
    end else begin
      idx_s = '0;
    end
  end

  // Stall, write strobe and load data selection.
  always_comb begin
    req_s  = bus.MEM_R_EN | bus.MEM_W_EN;
    done_s = (state_q == BUSY) && (cnt_q == {CNT_W{1'b0}});
    if (!rst_n) begin
      freeze_s = 1'b0;
    end else if (state_q == IDLE) begin
      freeze_s = req_s;
    end else begin
      freeze_s = (cnt_q != {CNT_W{1'b0}});
    end
    // A store pending when reset arrives is abandoned.
    we_s = rst_n & done_s & bus.MEM_W_EN & in_range_s;
    // R and W together behave as a store, so no load data is returned.
    if (in_range_s && bus.MEM_R_EN && !bus.MEM_W_EN) begin
      load_data_s = rdata_s;
    end else begin
      load_data_s = '0;
    end
  end

  // Next state of the sequencer, counter and MEM/WB register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wb_en_d = 1'b0;
    r_en_d  = 1'b0;
    alu_d   = '0;
    mdata_d = '0;
    dest_d  = 4'd0;
    aerr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end else begin
          wb_en_d = bus.MEM_WB_EN;
          alu_d   = bus.ALUResult;
          dest_d  = bus.Dest;
        end
      end
      BUSY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = IDLE;
          wb_en_d = bus.MEM_WB_EN;
          r_en_d  = bus.MEM_R_EN;
          alu_d   = bus.ALUResult;
          mdata_d = load_data_s;
          dest_d  = bus.Dest;
          aerr_d  = ~in_range_s;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and MEM/WB flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      wb_en_q <= 1'b0;
      r_en_q  <= 1'b0;
      alu_q   <= '0;
      mdata_q <= '0;
      dest_q  <= 4'd0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_en_q <= wb_en_d;
      r_en_q  <= r_en_d;
      alu_q   <= alu_d;
      mdata_q <= mdata_d;
      dest_q  <= dest_d;
      aerr_q  <= aerr_d;
    end
  end

  data_memory #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_data_memory (
    .clk   (clk),
    .we    (we_s),
    .idx   (idx_s),
    .wdata (bus.RMVal),
    .rdata (rdata_s)
  );

  assign bus.Freeze       = freeze_s;
  assign bus.WB_EN_Out    = wb_en_q;
  assign bus.MEM_R_EN_Out = r_en_q;
  assign bus.ALUResultOut = alu_q;
  assign bus.MemDataOut   = mdata_q;
  assign bus.DestOut      = dest_q;
  assign bus.AddrError    = aerr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: latency 2 main instance plus latency 1 and 7.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  mem_if #(.DATA_WIDTH(32)) if2 ();
  mem_if #(.DATA_WIDTH(32)) if1 ();
  mem_if #(.DATA_WIDTH(32)) if7 ();

  mem_stage #(.DATA_WIDTH(32), .DEPTH(64), .BASE_ADDR(1024), .MEM_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));
  mem_stage #(.DATA_WIDTH(32), .DEPTH(64), .BASE_ADDR(1024), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mem_stage #(.DATA_WIDTH(32), .DEPTH(64), .BASE_ADDR(1024), .MEM_LATENCY(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .bus(if7.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic r, input logic w, input logic wb,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] dest);
    if2.MEM_R_EN  = r;
    if2.MEM_W_EN  = w;
    if2.MEM_WB_EN = wb;
    if2.ALUResult = addr;
    if2.RMVal     = wdata;
    if2.Dest      = dest;
  endtask

  // One latency-2 access: Freeze must be high exactly 2 cycles with bubbles,
  // then the completion slot must carry the expected fields.
  task automatic op2(input string tag, input logic r, input logic w, input logic wb,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] dest,
                     input logic [31:0] exp_data, input logic exp_err);
    int n;
    n = 0;
    drive2(r, w, wb, addr, wdata, dest);
    #1;
    while (if2.Freeze === 1'b1 && n < 20) begin
      n++;
      @(posedge clk);
      #2;
      chk({tag, "_bubble_wb"}, {31'd0, if2.WB_EN_Out}, 32'd0);
    end
    chk({tag, "_freeze_cycles"}, 32'(n), 32'd2);
    tick();
    chk({tag, "_wb_en"}, {31'd0, if2.WB_EN_Out}, {31'd0, wb});
    chk({tag, "_r_en"}, {31'd0, if2.MEM_R_EN_Out}, {31'd0, r});
    chk({tag, "_alu"}, if2.ALUResultOut, addr);
    chk({tag, "_data"}, if2.MemDataOut, exp_data);
    chk({tag, "_dest"}, {28'd0, if2.DestOut}, {28'd0, dest});
    chk({tag, "_aerr"}, {31'd0, if2.AddrError}, {31'd0, exp_err});
    drive2(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    int cyc;
    int fz;
    rst_n = 1'b0;
    drive2(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    {if1.MEM_R_EN, if1.MEM_W_EN, if1.MEM_WB_EN} = 3'b000;
    {if1.ALUResult, if1.RMVal, if1.Dest} = {32'd0, 32'd0, 4'd0};
    {if7.MEM_R_EN, if7.MEM_W_EN, if7.MEM_WB_EN} = 3'b000;
    {if7.ALUResult, if7.RMVal, if7.Dest} = {32'd0, 32'd0, 4'd0};

    // Reset state.
    tick();
    tick();
    chk("rst_wb_en", {31'd0, if2.WB_EN_Out}, 32'd0);
    chk("rst_alu", if2.ALUResultOut, 32'd0);
    chk("rst_data", if2.MemDataOut, 32'd0);
    chk("rst_aerr", {31'd0, if2.AddrError}, 32'd0);
    drive2(1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd1);
    #1;
    chk("rst_freeze_forced", {31'd0, if2.Freeze}, 32'd0);
    drive2(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    rst_n = 1'b1;
    tick();

    // 1: non-memory op passes through in one cycle.
    drive2(1'b0, 1'b0, 1'b1, 32'h0000_0055, 32'd0, 4'd3);
    #1;
    chk("nonmem_freeze", {31'd0, if2.Freeze}, 32'd0);
    tick();
    chk("nonmem_wb_en", {31'd0, if2.WB_EN_Out}, 32'd1);
    chk("nonmem_alu", if2.ALUResultOut, 32'h0000_0055);
    chk("nonmem_dest", {28'd0, if2.DestOut}, 32'd3);
    chk("nonmem_r_en", {31'd0, if2.MEM_R_EN_Out}, 32'd0);
    drive2(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();

    // Preload: mem[1] and the last word mem[63].
    op2("pre1", 1'b0, 1'b1, 1'b0, 32'd1028, 32'hAAAA_AAAA, 4'd0, 32'd0, 1'b0);
    op2("pre63", 1'b0, 1'b1, 1'b0, 32'd1276, 32'h0000_0063, 4'd0, 32'd0, 1'b0);

    // 2: store then load at 1032 (mem[2]).
    op2("st2", 1'b0, 1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF, 4'd0, 32'd0, 1'b0);
    op2("ld2", 1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd5, 32'hDEAD_BEEF, 1'b0);

    // 3: out-of-range store below base and load just past the end.
    op2("st_oor", 1'b0, 1'b1, 1'b0, 32'd1020, 32'h0000_0099, 4'd0, 32'd0, 1'b1);
    tick();
    chk("oor_one_slot", {31'd0, if2.AddrError}, 32'd0);
    op2("ld63", 1'b1, 1'b0, 1'b1, 32'd1276, 32'd0, 4'd4, 32'h0000_0063, 1'b0);
    op2("ld_oor", 1'b1, 1'b0, 1'b1, 32'd1280, 32'd0, 4'd7, 32'd0, 1'b1);
    op2("ld2_again", 1'b1, 1'b0, 1'b1, 32'd1034, 32'd0, 4'd2, 32'hDEAD_BEEF, 1'b0);

    // 4: latency sweep, MEM_LATENCY=1.
    if1.MEM_W_EN = 1'b1; if1.MEM_WB_EN = 1'b1;
    if1.ALUResult = 32'd1024; if1.RMVal = 32'h11; if1.Dest = 4'd2;
    cyc = 0;
    fz = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (if1.Freeze === 1'b1) fz++;
      tick();
      cyc++;
      if (if1.WB_EN_Out === 1'b1) break;
    end
    chk("lat1_freeze", 32'(fz), 32'd1);
    chk("lat1_cycles", 32'(cyc), 32'd2);
    chk("lat1_dest", {28'd0, if1.DestOut}, 32'd2);
    {if1.MEM_W_EN, if1.MEM_WB_EN} = 2'b00;

    // 4: latency sweep, MEM_LATENCY=7.
    if7.MEM_R_EN = 1'b1; if7.MEM_WB_EN = 1'b1;
    if7.ALUResult = 32'd1100; if7.RMVal = 32'd0; if7.Dest = 4'd9;
    cyc = 0;
    fz = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (if7.Freeze === 1'b1) fz++;
      tick();
      cyc++;
      if (if7.WB_EN_Out === 1'b1) break;
    end
    chk("lat7_freeze", 32'(fz), 32'd7);
    chk("lat7_cycles", 32'(cyc), 32'd8);
    chk("lat7_r_en", {31'd0, if7.MEM_R_EN_Out}, 32'd1);
    {if7.MEM_R_EN, if7.MEM_WB_EN} = 2'b00;
    tick();

    // 5: reset during the first BUSY cycle abandons the store.
    drive2(1'b0, 1'b1, 1'b1, 32'd1028, 32'h0000_1234, 4'd6);
    #1;
    chk("rstb_freeze_req", {31'd0, if2.Freeze}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstb_freeze_low", {31'd0, if2.Freeze}, 32'd0);
    tick();
    chk("rstb_wb_en", {31'd0, if2.WB_EN_Out}, 32'd0);
    chk("rstb_alu", if2.ALUResultOut, 32'd0);
    rst_n = 1'b1;
    drive2(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    chk("rstb_idle_freeze", {31'd0, if2.Freeze}, 32'd0);
    tick();
    op2("ld1", 1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd8, 32'hAAAA_AAAA, 1'b0);

    // 6: R and W together act as a store.
    op2("rw3", 1'b1, 1'b1, 1'b1, 32'd1036, 32'd7, 4'd6, 32'd0, 1'b0);
    op2("ld3", 1'b1, 1'b0, 1'b1, 32'd1036, 32'd0, 4'd1, 32'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
